// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer preset block: FSM encoding, BCD digit widths and
// limits, and the mod-60 BCD increment used by both the minutes and seconds fields.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSet,
    StHandoff,
    StRunning
  } state_e;

  localparam int unsigned TENS_W = 3;
  localparam int unsigned ONES_W = 4;

  localparam logic [ONES_W-1:0] ONES_MAX = 4'd9;
  localparam logic [TENS_W-1:0] TENS_MAX = 3'd5;

  // One mod-60 BCD step on a {tens, ones} pair; 59 wraps to 00.
  function automatic logic [TENS_W+ONES_W-1:0] bcd_inc(input logic [TENS_W-1:0] tens,
                                                       input logic [ONES_W-1:0] ones);
    logic [TENS_W+ONES_W-1:0] res;
    if (ones != ONES_MAX) begin
      res = {tens, ones + 4'd1};
    end else if (tens != TENS_MAX) begin
      res = {tens + 3'd1, 4'd0};
    end else begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Turns a debounced button level into one-cycle increment pulses: on the rising edge and, when
// AUTO_REPEAT_EN is defined, periodically while the button stays held in set mode.
module button_conditioner #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic active,
  input  logic btn,
  output logic inc_pulse
);

  logic prev_q;

  // Tracks the button even while disabled, so edges during disable are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= btn;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned CntW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CntW-1:0] DelayCnt = CntW'(REPEAT_DELAY);
  // Re-entry value so the next match lands REPEAT_PERIOD cycles later.
  localparam logic [CntW-1:0] RearmCnt = CntW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (!(active && btn)) begin
        cnt_d = '0;
      end else if (cnt_q == DelayCnt) begin
        cnt_d = RearmCnt;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign inc_pulse = (btn & ~prev_q) | (active & btn & (cnt_q == DelayCnt));
`else
  logic unused_inputs;
  assign unused_inputs = ^{active, enable, REPEAT_DELAY, REPEAT_PERIOD};
  assign inc_pulse = btn & ~prev_q;
`endif

endmodule

// File: rtl/egg_timer_set_counter.sv
// Egg timer mm:ss preset entry: buttons increment a BCD preset in set mode, start hands it to the
// countdown over valid/ready, then the block locks until done. Optional: AUTO_REPEAT_EN.
module egg_timer_set_counter
  import egg_timer_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cook_time,
  input  logic       minutes,
  input  logic       seconds,
  input  logic       start,
  input  logic       load_ready,
  input  logic       done,
  output logic       load_valid,
  output logic [2:0] m_tens_Up,
  output logic [3:0] m_ones_Up,
  output logic [2:0] s_tens_Up,
  output logic [3:0] s_ones_Up,
  output logic       busy
);

  state_e state_q, state_d;
  logic [TENS_W-1:0] m_tens_q, m_tens_d, s_tens_q, s_tens_d;
  logic [ONES_W-1:0] m_ones_q, m_ones_d, s_ones_q, s_ones_d;
  logic start_q;
  logic start_rise, inc_m, inc_s, in_set, preset_zero;

  assign in_set      = (state_q == StSet);
  assign start_rise  = start & ~start_q;
  assign preset_zero = ({m_tens_q, m_ones_q, s_tens_q, s_ones_q} == '0);

  button_conditioner #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_min_btn (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .active   (in_set),
    .btn      (minutes),
    .inc_pulse(inc_m)
  );

  button_conditioner #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_sec_btn (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .active   (in_set),
    .btn      (seconds),
    .inc_pulse(inc_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      m_tens_q <= '0;
      m_ones_q <= '0;
      s_tens_q <= '0;
      s_ones_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      m_tens_q <= m_tens_d;
      m_ones_q <= m_ones_d;
      s_tens_q <= s_tens_d;
      s_ones_q <= s_ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        StIdle:    if (cook_time) state_d = StSet;
        StSet: begin
          if (!cook_time) begin
            state_d = StIdle;
          end else if (start_rise && !preset_zero) begin
            state_d = StHandoff;
          end
        end
        StHandoff: if (load_ready) state_d = StRunning;
        StRunning: if (done) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    {m_tens_d, m_ones_d} = {m_tens_q, m_ones_q};
    {s_tens_d, s_ones_d} = {s_tens_q, s_ones_q};
    if (enable && in_set) begin
      if (inc_m) {m_tens_d, m_ones_d} = bcd_inc(m_tens_q, m_ones_q);
      if (inc_s) {s_tens_d, s_ones_d} = bcd_inc(s_tens_q, s_ones_q);
    end else if (enable && (state_q == StRunning) && done) begin
      {m_tens_d, m_ones_d, s_tens_d, s_ones_d} = '0;
    end
  end

  // Decoded straight from the state register so reset drops load_valid asynchronously.
  always_comb begin
    load_valid = (state_q == StHandoff);
    busy       = (state_q == StHandoff) || (state_q == StRunning);
    m_tens_Up  = m_tens_q;
    m_ones_Up  = m_ones_q;
    s_tens_Up  = s_tens_q;
    s_ones_Up  = s_ones_q;
  end

endmodule
